rename_regfile: RTL and testbench

RENAME_REGFILE -- requirements
Module: rename_regfile

---
 rtl/rename_regfile.sv | 100 ++++++++++
 tb/tb_rename_regfile.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rename_regfile
// Description : Architectural register file with rename tags for a Tomasulo-
//               style core. Each register holds a committed value and the ROB
//               tag of its youngest in-flight producer (0 = value is final).
//               Two combinational read ports with a commit bypass, one commit
//               write port and one dispatch (rename) port per cycle.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               rdy                       - global enable (low = freeze state)
//               flush                     - misprediction flush, clears all tags
//               commit_valid/_rd/_res/_dependency - ROB commit write port
//               dispatch_valid/_rd, rename_rd     - rename of a destination reg
//               rs1, rs2                  - source register indices
//               Qi/Vi, Qj/Vj              - pending tag / value for rs1 / rs2
// Revision    : 1.0 - initial release
// ============================================================================
module rename_regfile #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              commit_valid,
    input  logic [4:0]        commit_rd,
    input  logic [31:0]       commit_res,
    input  logic [TAG_W-1:0]  commit_dependency,
    input  logic              dispatch_valid,
    input  logic [4:0]        dispatch_rd,
    input  logic [TAG_W-1:0]  rename_rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic [TAG_W-1:0]  Qi,
    output logic [TAG_W-1:0]  Qj,
    output logic [31:0]       Vi,
    output logic [31:0]       Vj
);

    localparam logic [4:0] c_X0 = 5'd0;

    logic [31:0]      r_val [NUM_REGS];
    logic [TAG_W-1:0] r_tag [NUM_REGS];

    logic w_commit;
    logic w_commit_clears;
    logic w_dispatch;
    logic w_byp_i;
    logic w_byp_j;

    // Writes to x0 are dropped here, so x0 keeps its reset value of zero.
    assign w_commit        = commit_valid && (commit_rd != c_X0);
    // Only the producer the register is still waiting on may clear its tag;
    // a younger rename of the same register must stay pending.
    assign w_commit_clears = w_commit && (r_tag[commit_rd] == commit_dependency);
    assign w_dispatch      = dispatch_valid && (dispatch_rd != c_X0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (rdy) begin
            if (w_commit) begin
                r_val[commit_rd] <= commit_res;
            end
            if (flush) begin
                // Values survive a flush; only the speculative renames die.
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_tag[i] <= '0;
                end
            end else begin
                if (w_commit_clears) begin
                    r_tag[commit_rd] <= '0;
                end
                // Placed after the commit clear so a same-register dispatch
                // wins the tag.
                if (w_dispatch) begin
                    r_tag[dispatch_rd] <= rename_rd;
                end
            end
        end
    end

    // Commit bypass: a reader waiting on the producer committing this cycle
    // sees the result immediately instead of one cycle later.
    assign w_byp_i = commit_valid && rdy && !rst && (rs1 != c_X0) &&
                     (commit_rd == rs1) && (r_tag[rs1] == commit_dependency);
    assign w_byp_j = commit_valid && rdy && !rst && (rs2 != c_X0) &&
                     (commit_rd == rs2) && (r_tag[rs2] == commit_dependency);

    assign Qi = w_byp_i ? '0         : r_tag[rs1];
    assign Vi = w_byp_i ? commit_res : r_val[rs1];
    assign Qj = w_byp_j ? '0         : r_tag[rs2];
    assign Vj = w_byp_j ? commit_res : r_val[rs2];

endmodule
`default_nettype wire

// File: tb/tb_rename_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_regfile
// Description : Self-checking bench for rename_regfile. Directed scenarios
//               with fixed expected values, then random traffic compared with
//               a behavioural register/tag model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_res;
    logic [4:0]  commit_dependency;
    logic        dispatch_valid;
    logic [4:0]  dispatch_rd;
    logic [4:0]  rename_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  Qi;
    logic [4:0]  Qj;
    logic [31:0] Vi;
    logic [31:0] Vj;

    int checks = 0;
    int errors = 0;

    // Behavioural model: architectural values and pending producer tags.
    logic [31:0] m_val [32];
    logic [4:0]  m_tag [32];

    rename_regfile #(.NUM_REGS(32), .TAG_W(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .flush             (flush),
        .commit_valid      (commit_valid),
        .commit_rd         (commit_rd),
        .commit_res        (commit_res),
        .commit_dependency (commit_dependency),
        .dispatch_valid    (dispatch_valid),
        .dispatch_rd       (dispatch_rd),
        .rename_rd         (rename_rd),
        .rs1               (rs1),
        .rs2               (rs2),
        .Qi                (Qi),
        .Qj                (Qj),
        .Vi                (Vi),
        .Vj                (Vj)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        commit_valid = 1'b0; commit_rd = '0; commit_res = '0; commit_dependency = '0;
        dispatch_valid = 1'b0; dispatch_rd = '0; rename_rd = '0;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] dep, input logic [31:0] res);
        commit_valid = 1'b1; commit_rd = rd; commit_dependency = dep; commit_res = res;
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic [4:0] tag);
        dispatch_valid = 1'b1; dispatch_rd = rd; rename_rd = tag;
    endtask

    // Register state as seen at the next edge, written from the rules:
    // reset clears everything; rdy low freezes; a commit always writes the
    // value and retires the tag only if it is still the awaited producer;
    // flush discards every rename; otherwise a dispatch renames its register.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0;
                m_tag[i] = '0;
            end
        end else if (rdy) begin
            if (commit_valid && commit_rd != 0) begin
                m_val[commit_rd] = commit_res;
                if (m_tag[commit_rd] == commit_dependency) m_tag[commit_rd] = '0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_tag[i] = '0;
            end else if (dispatch_valid && dispatch_rd != 0) begin
                m_tag[dispatch_rd] = rename_rd;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic void exp_read(input logic [4:0] rs, output logic [4:0] q, output logic [31:0] v);
        q = m_tag[rs];
        v = m_val[rs];
        if (commit_valid && rdy && !rst && rs != 0 && commit_rd == rs &&
            m_tag[rs] == commit_dependency) begin
            q = '0;
            v = commit_res;
        end
    endfunction

    task automatic chk_model(input string name);
        logic [4:0]  q;
        logic [31:0] v;
        exp_read(rs1, q, v);
        chk({name, "_Qi"}, 32'(Qi), 32'(q));
        chk({name, "_Vi"}, Vi, v);
        exp_read(rs2, q, v);
        chk({name, "_Qj"}, 32'(Qj), 32'(q));
        chk({name, "_Vj"}, Vj, v);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 'x;
            m_tag[i] = 'x;
        end
        idle();
        rs1 = 5'd3; rs2 = 5'd17;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        // Reset state, several read addresses.
        chk("rst_Qi", 32'(Qi), 32'd0);
        chk("rst_Vi", Vi, 32'd0);
        chk("rst_Qj", 32'(Qj), 32'd0);
        chk("rst_Vj", Vj, 32'd0);
        rs1 = 5'd31; rs2 = 5'd0; #1;
        chk("rst2_Qi", 32'(Qi), 32'd0);
        chk("rst2_Vj", Vj, 32'd0);

        // Rename then bypassed commit.
        dispatch(5'd5, 5'd3);
        rs1 = 5'd5; #1;
        chk("samecyc_disp_Qi", 32'(Qi), 32'd0);
        step();
        idle();
        #1;
        chk("renamed_Qi", 32'(Qi), 32'd3);
        chk("renamed_Vi", Vi, 32'd0);
        commit(5'd5, 5'd3, 32'h1234);
        #1;
        chk("bypass_Qi", 32'(Qi), 32'd0);
        chk("bypass_Vi", Vi, 32'h1234);
        step();
        idle();
        #1;
        chk("committed_Qi", 32'(Qi), 32'd0);
        chk("committed_Vi", Vi, 32'h1234);

        // Stale commit must not clear a newer rename.
        dispatch(5'd7, 5'd2); step();
        dispatch(5'd7, 5'd4); step();
        idle();
        commit(5'd7, 5'd2, 32'd9);
        rs2 = 5'd7; #1;
        chk("stale_nobyp_Qj", 32'(Qj), 32'd4);
        chk("stale_nobyp_Vj", Vj, 32'd0);
        step();
        idle();
        #1;
        chk("stale_Qj", 32'(Qj), 32'd4);
        chk("stale_Vj", Vj, 32'd9);

        // x0 is hard-wired.
        dispatch(5'd0, 5'd6);
        commit(5'd0, 5'd0, 32'hFFFF);
        rs1 = 5'd0; #1;
        chk("x0_same_Qi", 32'(Qi), 32'd0);
        chk("x0_same_Vi", Vi, 32'd0);
        step();
        idle();
        #1;
        chk("x0_Qi", 32'(Qi), 32'd0);
        chk("x0_Vi", Vi, 32'd0);

        // Same-register dispatch and commit: value from commit, tag from dispatch.
        commit(5'd5, 5'd0, 32'hAB);
        dispatch(5'd5, 5'd9);
        step();
        idle();
        rs1 = 5'd5; #1;
        chk("collide_Qi", 32'(Qi), 32'd9);
        chk("collide_Vi", Vi, 32'hAB);

        // Flush with concurrent commit and dispatch.
        dispatch(5'd1, 5'd1); step();
        dispatch(5'd2, 5'd2); step();
        dispatch(5'd3, 5'd3); step();
        idle();
        flush = 1'b1;
        commit(5'd1, 5'd1, 32'd5);
        dispatch(5'd4, 5'd7);
        step();
        idle();
        rs1 = 5'd1; rs2 = 5'd4; #1;
        chk("flush_Q1", 32'(Qi), 32'd0);
        chk("flush_V1", Vi, 32'd5);
        chk("flush_Q4", 32'(Qj), 32'd0);
        rs1 = 5'd2; rs2 = 5'd3; #1;
        chk("flush_Q2", 32'(Qi), 32'd0);
        chk("flush_Q3", 32'(Qj), 32'd0);
        rs1 = 5'd7; rs2 = 5'd5; #1;
        chk("flush_Q7", 32'(Qi), 32'd0);
        chk("flush_V5", Vj, 32'hAB);

        // rdy low freezes state and disables the bypass.
        rdy = 1'b0;
        dispatch(5'd8, 5'd5);
        commit(5'd9, 5'd0, 32'd1);
        rs1 = 5'd9; #1;
        chk("rdy0_nobyp_Vi", Vi, 32'd0);
        step();
        rs1 = 5'd8; rs2 = 5'd9; #1;
        chk("rdy0_Q8", 32'(Qi), 32'd0);
        chk("rdy0_V9", Vj, 32'd0);
        rdy = 1'b1;
        step();
        idle();
        #1;
        chk("rdy1_Q8", 32'(Qi), 32'd5);
        chk("rdy1_V9", Vj, 32'd1);

        // Reset overrides concurrent commit and dispatch.
        dispatch(5'd10, 5'd11); step();
        idle();
        rst = 1'b1;
        commit(5'd8, 5'd5, 32'h55);
        dispatch(5'd9, 5'd12);
        step();
        idle();
        rs1 = 5'd8; rs2 = 5'd9; #1;
        chk("rstop_Qi", 32'(Qi), 32'd0);
        chk("rstop_Vi", Vi, 32'd0);
        chk("rstop_Qj", 32'(Qj), 32'd0);
        chk("rstop_Vj", Vj, 32'd0);
        rs1 = 5'd10; rs2 = 5'd1; #1;
        chk("rstop_Q10", 32'(Qi), 32'd0);
        chk("rstop_V1", Vj, 32'd0);

        // Random traffic against the model (registers 0..7 to force collisions).
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom % 64) == 0;
            rdy            = ($urandom % 8) != 0;
            flush          = ($urandom % 16) == 0;
            commit_valid   = $urandom % 2;
            commit_rd      = 5'($urandom % 8);
            commit_dependency = (($urandom % 4) != 0) ? m_tag[commit_rd] : 5'($urandom);
            commit_res     = $urandom;
            dispatch_valid = $urandom % 2;
            dispatch_rd    = 5'($urandom % 8);
            rename_rd      = 5'($urandom_range(1, 31));
            rs1            = ($urandom % 2) ? commit_rd : 5'($urandom % 8);
            rs2            = 5'($urandom % 8);
            #1;
            chk_model("rand");
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
